// File: rtl/pe_mac_ws_param.sv
// Weight-stationary MAC processing element with parametrised widths, double-buffered
// weights, valid-tagged pixels, signed/unsigned per sample and saturating accumulation.
module pe_mac_ws_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned W_W      = 8,
   parameter int unsigned ACC_W    = 32,
   parameter int unsigned PIPE_MUL = 1,
   parameter int unsigned SAT_EN   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              signed_mode,
   input  logic [W_W-1:0]    w_in,
   input  logic              w_load,
   input  logic              w_swap,
   output logic [W_W-1:0]    w_out,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid_in,
   output logic [DATA_W-1:0] pix_out,
   output logic              pix_valid_out,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic [ACC_W-1:0]  psum_mem_in,
   input  logic              psum_sel,
   input  logic              acc_clr,
   output logic [ACC_W-1:0]  psum_out,
   output logic              psum_valid_out,
   output logic              ovf_out
);

   localparam int unsigned P_W   = DATA_W + W_W;
   localparam int unsigned EXT_W = ACC_W - P_W;

   logic [W_W-1:0]    r_w_shadow;
   logic [W_W-1:0]    r_w_active;
   logic [DATA_W-1:0] r_pix;
   logic              r_pix_valid;
   logic [ACC_W-1:0]  r_psum;
   logic              r_psum_valid;
   logic              r_ovf;

   logic [P_W-1:0]    w_pix_ext;
   logic [P_W-1:0]    w_wgt_ext;
   logic [P_W-1:0]    w_prod;
   logic [P_W-1:0]    w_s2_prod;
   logic              w_s2_valid;
   logic              w_s2_signed;
   logic [ACC_W-1:0]  w_base;
   logic [ACC_W-1:0]  w_p_ext;
   logic [ACC_W:0]    w_sum_full;
   logic [ACC_W-1:0]  w_sum;
   logic [ACC_W-1:0]  w_sat_val;
   logic [ACC_W-1:0]  w_result;
   logic              w_ovf;

   // Weight double buffer runs regardless of en; a swap takes the pre-load shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_shadow <= '0;
         r_w_active <= '0;
      end else begin
         if (w_load) r_w_shadow <= w_in;
         if (w_swap) r_w_active <= r_w_shadow;
      end
   end

   assign w_out = r_w_shadow;

   // Extending both operands to the product width gives the right low bits in either mode
   assign w_pix_ext = {{W_W{signed_mode & pix_in[DATA_W-1]}}, pix_in};
   assign w_wgt_ext = {{DATA_W{signed_mode & r_w_active[W_W-1]}}, r_w_active};
   assign w_prod    = w_pix_ext * w_wgt_ext;

   if (PIPE_MUL != 0) begin : g_pipe
      logic [P_W-1:0] r_prod;
      logic           r_valid;
      logic           r_signed;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_prod   <= '0;
            r_valid  <= 1'b0;
            r_signed <= 1'b0;
         end else if (en) begin
            r_prod   <= w_prod;
            r_valid  <= pix_valid_in;
            r_signed <= signed_mode;
         end
      end

      assign w_s2_prod   = r_prod;
      assign w_s2_valid  = r_valid;
      assign w_s2_signed = r_signed;
   end else begin : g_comb
      assign w_s2_prod   = w_prod;
      assign w_s2_valid  = pix_valid_in;
      assign w_s2_signed = signed_mode;
   end

   assign w_base     = acc_clr ? '0 : (psum_sel ? psum_mem_in : psum_in);
   assign w_p_ext    = {{EXT_W{w_s2_signed & w_s2_prod[P_W-1]}}, w_s2_prod};
   assign w_sum_full = {1'b0, w_base} + {1'b0, w_p_ext};
   assign w_sum      = w_sum_full[ACC_W-1:0];

   // Overflow detection and clamp value depend on the sample's own signedness
   always_comb begin
      w_ovf     = 1'b0;
      w_sat_val = '1;
      w_result  = w_sum;
      if (w_s2_signed) begin
         w_ovf     = (w_base[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != w_base[ACC_W-1]);
         w_sat_val = w_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         w_ovf     = w_sum_full[ACC_W];
      end
      if (w_ovf && (SAT_EN != 0)) w_result = w_sat_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix        <= '0;
         r_pix_valid  <= 1'b0;
         r_psum       <= '0;
         r_psum_valid <= 1'b0;
         r_ovf        <= 1'b0;
      end else if (en) begin
         r_pix       <= pix_in;
         r_pix_valid <= pix_valid_in;
         if (w_s2_valid) begin
            r_psum       <= w_result;
            r_psum_valid <= 1'b1;
            r_ovf        <= w_ovf;
         end else begin
            r_psum       <= w_base;
            r_psum_valid <= 1'b0;
            r_ovf        <= 1'b0;
         end
      end
   end

   assign pix_out        = r_pix;
   assign pix_valid_out  = r_pix_valid;
   assign psum_out       = r_psum;
   assign psum_valid_out = r_psum_valid;
   assign ovf_out        = r_ovf;

endmodule

// File: tb/tb_pe_mac_ws_param.sv
// Bench for pe_mac_ws_param: three parameterisations share one stimulus stream and are
// checked against an arithmetic model (true-range overflow, modulo wrap, clamp).
module tb_pe_mac_ws_param;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        signed_mode;
   logic [7:0]  w_in;
   logic        w_load;
   logic        w_swap;
   logic [7:0]  pix_in;
   logic        pix_valid_in;
   logic [31:0] psum_in;
   logic [31:0] psum_mem_in;
   logic        psum_sel;
   logic        acc_clr;

   logic [7:0]  d0_w_out, d1_w_out, d2_w_out;
   logic [7:0]  d0_pix, d1_pix, d2_pix;
   logic        d0_pixv, d1_pixv, d2_pixv;
   logic [31:0] d0_psum;
   logic [16:0] d1_psum, d2_psum;
   logic        d0_pv, d1_pv, d2_pv;
   logic        d0_ovf, d1_ovf, d2_ovf;

   int n_pass  = 0;
   int n_total = 0;

   // model state
   logic [7:0]  m_shadow, m_active, m_pix;
   bit          m_pixv;
   longint      m_p1_prod;
   bit          m_p1_v, m_p1_s;
   logic [31:0] e_ps [3];
   bit          e_pv [3];
   bit          e_ov [3];

   pe_mac_ws_param u_d0 (
      .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(signed_mode),
      .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .w_out(d0_w_out),
      .pix_in(pix_in), .pix_valid_in(pix_valid_in), .pix_out(d0_pix), .pix_valid_out(d0_pixv),
      .psum_in(psum_in), .psum_mem_in(psum_mem_in), .psum_sel(psum_sel), .acc_clr(acc_clr),
      .psum_out(d0_psum), .psum_valid_out(d0_pv), .ovf_out(d0_ovf));

   pe_mac_ws_param #(.ACC_W(17), .PIPE_MUL(1), .SAT_EN(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(signed_mode),
      .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .w_out(d1_w_out),
      .pix_in(pix_in), .pix_valid_in(pix_valid_in), .pix_out(d1_pix), .pix_valid_out(d1_pixv),
      .psum_in(psum_in[16:0]), .psum_mem_in(psum_mem_in[16:0]), .psum_sel(psum_sel),
      .acc_clr(acc_clr), .psum_out(d1_psum), .psum_valid_out(d1_pv), .ovf_out(d1_ovf));

   pe_mac_ws_param #(.ACC_W(17), .PIPE_MUL(0), .SAT_EN(0)) u_d2 (
      .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(signed_mode),
      .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .w_out(d2_w_out),
      .pix_in(pix_in), .pix_valid_in(pix_valid_in), .pix_out(d2_pix), .pix_valid_out(d2_pixv),
      .psum_in(psum_in[16:0]), .psum_mem_in(psum_mem_in[16:0]), .psum_sel(psum_sel),
      .acc_clr(acc_clr), .psum_out(d2_psum), .psum_valid_out(d2_pv), .ovf_out(d2_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic longint prod_of(input logic [7:0] p, input logic [7:0] w, input bit s);
      if (s) return longint'($signed(p)) * longint'($signed(w));
      return longint'(p) * longint'(w);
   endfunction

   // Result of one stage-2 update: exact sum, range test, then clamp or wrap
   function automatic void calc(input longint prod, input bit s, input bit v,
                                input logic [31:0] base_raw, input int aw, input bit sat,
                                output logic [31:0] r, output bit rv, output bit ro);
      longint modv, base, sum, lo, hi;
      modv = longint'(1) << aw;
      base = longint'(base_raw) & (modv - 1);
      if (!v) begin
         r  = 32'(base);
         rv = 1'b0;
         ro = 1'b0;
         return;
      end
      if (s) begin
         if (base >= modv / 2) base = base - modv;
         lo = -(modv / 2);
         hi = modv / 2 - 1;
      end else begin
         lo = 0;
         hi = modv - 1;
      end
      sum = base + prod;
      rv  = 1'b1;
      ro  = (sum < lo) || (sum > hi);
      if (ro && sat) sum = (sum < lo) ? lo : hi;
      r = 32'(sum & (modv - 1));
   endfunction

   task automatic model_reset();
      m_shadow = '0; m_active = '0; m_pix = '0; m_pixv = 0;
      m_p1_prod = 0; m_p1_v = 0; m_p1_s = 0;
      for (int k = 0; k < 3; k++) begin
         e_ps[k] = '0; e_pv[k] = 0; e_ov[k] = 0;
      end
   endtask

   task automatic model_edge();
      longint      pnow;
      logic [31:0] base;
      pnow = prod_of(pix_in, m_active, signed_mode);
      base = acc_clr ? 32'd0 : (psum_sel ? psum_mem_in : psum_in);
      if (en) begin
         calc(m_p1_prod, m_p1_s, m_p1_v, base, 32, 1'b1, e_ps[0], e_pv[0], e_ov[0]);
         calc(m_p1_prod, m_p1_s, m_p1_v, base, 17, 1'b1, e_ps[1], e_pv[1], e_ov[1]);
         calc(pnow, signed_mode, pix_valid_in, base, 17, 1'b0, e_ps[2], e_pv[2], e_ov[2]);
         m_p1_prod = pnow;
         m_p1_v    = pix_valid_in;
         m_p1_s    = signed_mode;
         m_pix     = pix_in;
         m_pixv    = pix_valid_in;
      end
      if (w_swap) m_active = m_shadow;
      if (w_load) m_shadow = w_in;
   endtask

   task automatic check_all();
      chk("pix_out",    32'(d0_pix),  32'(m_pix));
      chk("pix_valid",  32'(d0_pixv), 32'(m_pixv));
      chk("w_out",      32'(d0_w_out), 32'(m_shadow));
      chk("pix_out_p0", 32'(d2_pix),  32'(m_pix));
      chk("psum_a32",   d0_psum,      e_ps[0]);
      chk("valid_a32",  32'(d0_pv),   32'(e_pv[0]));
      chk("ovf_a32",    32'(d0_ovf),  32'(e_ov[0]));
      chk("psum_sat17", 32'(d1_psum), e_ps[1]);
      chk("valid_sat17", 32'(d1_pv),  32'(e_pv[1]));
      chk("ovf_sat17",  32'(d1_ovf),  32'(e_ov[1]));
      chk("psum_wrap17", 32'(d2_psum), e_ps[2]);
      chk("valid_wrap17", 32'(d2_pv), 32'(e_pv[2]));
      chk("ovf_wrap17", 32'(d2_ovf),  32'(e_ov[2]));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_w_out"},  32'(d0_w_out), 32'd0);
      chk({tag, "_pix"},    32'(d0_pix),   32'd0);
      chk({tag, "_pixv"},   32'(d0_pixv),  32'd0);
      chk({tag, "_psum"},   d0_psum,       32'd0);
      chk({tag, "_pv"},     32'(d0_pv),    32'd0);
      chk({tag, "_ovf"},    32'(d0_ovf),   32'd0);
      chk({tag, "_pv17"},   32'(d1_pv),    32'd0);
      chk({tag, "_psum17"}, 32'(d1_psum),  32'd0);
      chk({tag, "_pv_p0"},  32'(d2_pv),    32'd0);
      chk({tag, "_psum_p0"}, 32'(d2_psum), 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      en = 1'b1; signed_mode = 1'b0; w_in = '0; w_load = 1'b0; w_swap = 1'b0;
      pix_in = '0; pix_valid_in = 1'b0; psum_in = '0; psum_mem_in = '0;
      psum_sel = 1'b0; acc_clr = 1'b0;
   endtask

   task automatic set_weight(input logic [7:0] w);
      w_in = w; w_load = 1'b1; step();
      w_load = 1'b0; w_swap = 1'b1; step();
      w_swap = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #2;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // unsigned basic
      set_weight(8'd200);
      pix_in = 8'd250; pix_valid_in = 1'b1; psum_in = 32'd100;
      step();
      chk("basic_pix_out", 32'(d0_pix), 32'd250);
      step();
      chk("basic_psum", d0_psum, 32'd50100);
      chk("basic_valid", 32'(d0_pv), 32'd1);
      pix_valid_in = 1'b0;

      // signed versus unsigned interpretation
      set_weight(8'hFE);
      pix_in = 8'h05; pix_valid_in = 1'b1; signed_mode = 1'b1; psum_in = 32'd10;
      step(); step();
      chk("signed_psum", d0_psum, 32'd0);
      signed_mode = 1'b0;
      step(); step();
      chk("unsigned_psum", d0_psum, 32'd1280);
      pix_valid_in = 1'b0;

      // saturation and wrap on a 17-bit accumulator
      set_weight(8'd127);
      pix_in = 8'd127; pix_valid_in = 1'b1; signed_mode = 1'b1; psum_in = 32'd65535;
      step(); step();
      chk("sat_psum", 32'(d1_psum), 32'h0000FFFF);
      chk("sat_ovf", 32'(d1_ovf), 32'd1);
      chk("wrap_psum", 32'(d2_psum), 32'h00013F00);
      chk("wrap_ovf", 32'(d2_ovf), 32'd1);
      chk("wide_no_ovf", d0_psum, 32'd81664);
      pix_valid_in = 1'b0; signed_mode = 1'b0; psum_in = '0;

      // double buffer: swap in the pixel cycle uses the old active weight
      set_weight(8'd3);
      w_in = 8'd7; w_load = 1'b1; step();
      w_in = 8'd9; w_load = 1'b1; w_swap = 1'b1;
      pix_in = 8'd2; pix_valid_in = 1'b1;
      step();
      w_load = 1'b0; w_swap = 1'b0;
      step();
      chk("dbuf_old_w", d0_psum, 32'd6);
      pix_valid_in = 1'b0;
      step();
      chk("dbuf_new_w", d0_psum, 32'd14);
      chk("dbuf_w_out", 32'(d0_w_out), 32'd9);

      // stall mid-stream, then a bubble passes psum_in through
      pix_valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pix_in  = 8'(i + 1);
         psum_in = 32'(i * 3);
         en      = !(i >= 4 && i < 7);
         step();
      end
      en = 1'b1; pix_valid_in = 1'b0; psum_in = 32'd12345;
      step(); step();
      chk("bubble_psum", d0_psum, 32'd12345);
      chk("bubble_valid", 32'(d0_pv), 32'd0);

      // base select and clear (active weight is 7)
      pix_in = 8'd10; pix_valid_in = 1'b1; psum_sel = 1'b1;
      psum_mem_in = 32'd1000; psum_in = 32'd5;
      step(); step();
      chk("mem_base", d0_psum, 32'd1070);
      acc_clr = 1'b1;
      step(); step();
      chk("clr_base", d0_psum, 32'd70);
      idle();

      // reset mid-stream discards in-flight samples
      pix_in = 8'd9; pix_valid_in = 1'b1; psum_in = 32'd77;
      step();
      pulse_reset();
      idle();
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_valid", 32'(d0_pv), 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         en           = ($urandom_range(0, 4) != 0);
         signed_mode  = 1'($urandom_range(0, 1));
         pix_in       = 8'($urandom);
         pix_valid_in = ($urandom_range(0, 3) != 0);
         w_in         = 8'($urandom);
         w_load       = ($urandom_range(0, 3) == 0);
         w_swap       = ($urandom_range(0, 5) == 0);
         psum_sel     = 1'($urandom_range(0, 1));
         acc_clr      = ($urandom_range(0, 7) == 0);
         psum_mem_in  = 32'($urandom);
         case ($urandom_range(0, 4))
            0:       psum_in = 32'($urandom);
            1:       psum_in = 32'h0000FF00 + 32'($urandom_range(0, 255));
            2:       psum_in = 32'h7FFFFF00 + 32'($urandom_range(0, 255));
            3:       psum_in = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
            default: psum_in = 32'h0001FF00 + 32'($urandom_range(0, 255));
         endcase
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
